// File: rtl/disp_timing_gen_pkg.sv
// Shared timing defaults and FSM encoding for the display timing generator.
package disp_timing_gen_pkg;

   // Default panel timing (640x400 @ 800x449 total)
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 400;
   localparam int DEF_V_FP     = 12;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 35;
   localparam int DEF_LOCK_CYC = 1024;
   localparam int DEF_CW       = 11;

   typedef enum logic {
      ST_WAIT_LOCK = 1'b0,
      ST_RUN       = 1'b1
   } run_state_t;

   // Total span of one axis: active + front porch + sync + back porch
   function automatic int span_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

endpackage

// File: rtl/disp_lock_filter.sv
// PLL lock synchroniser and qualification counter; lock_ok is asserted only
// after LOCK_CYC consecutive synced lock-high cycles and drops together with
// the synced lock.
module disp_lock_filter #(
   parameter int LOCK_CYC = 1024
) (
   input  logic clk,
   input  logic resetn,
   input  logic pll_lock,
   output logic lock_ok
);

   localparam int LW = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
   localparam logic [LW-1:0] CNT_LAST = LW'(LOCK_CYC - 1);

   logic          lock_meta;
   logic          lock_sync;
   logic [LW-1:0] cnt;

   // Two-flop synchroniser for the asynchronous lock input
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lock_meta <= 1'b0;
         lock_sync <= 1'b0;
      end else begin
         lock_meta <= pll_lock;
         lock_sync <= lock_meta;
      end
   end

   // Count consecutive synced lock-high cycles, saturating at the last value
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt <= '0;
      end else if (!lock_sync) begin
         cnt <= '0;
      end else if (cnt != CNT_LAST) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign lock_ok = lock_sync && (cnt == CNT_LAST);

endmodule

// File: rtl/disp_timing_gen.sv
// Video timing generator: lock-gated run FSM, x/y raster counters, registered
// sync/de/strobe decode and a sticky pixel underrun flag.
module disp_timing_gen
   import disp_timing_gen_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int LOCK_CYC = DEF_LOCK_CYC,
   parameter int CW       = DEF_CW
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          pll_lock,
   input  logic          pix_valid,
   output logic          pix_ready,
   output logic          hsync,
   output logic          vsync,
   output logic          de,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          line_start,
   output logic          frame_start,
   output logic          running,
   output logic          underrun,
   input  logic          underrun_clr
);

   localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

   logic          lock_ok;
   run_state_t    state;
   run_state_t    state_nxt;
   logic          vld_p0;
   logic [CW-1:0] hx_p0;
   logic [CW-1:0] vy_p0;
   logic          de_p0;
   logic          hs_act_p0;
   logic          vs_act_p0;
   logic          ls_p0;
   logic          fs_p0;

   disp_lock_filter #(
      .LOCK_CYC (LOCK_CYC)
   ) u_lock_filter (
      .clk      (clk),
      .resetn   (resetn),
      .pll_lock (pll_lock),
      .lock_ok  (lock_ok)
   );

   // Run-state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= ST_WAIT_LOCK;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state; raster is valid only while in RUN with lock still good, so
   // a lock loss idles the outputs on the very next edge
   always_comb begin
      state_nxt = state;
      vld_p0    = 1'b0;
      case (state)
         ST_WAIT_LOCK: if (lock_ok) state_nxt = ST_RUN;
         ST_RUN: begin
            vld_p0 = lock_ok;
            if (!lock_ok) state_nxt = ST_WAIT_LOCK;
         end
         default: state_nxt = ST_WAIT_LOCK;
      endcase
   end

   // ---- stage p0: raster counters (held at origin while not running) ----
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hx_p0 <= '0;
         vy_p0 <= '0;
      end else if (!vld_p0) begin
         hx_p0 <= '0;
         vy_p0 <= '0;
      end else if (hx_p0 == H_LAST) begin
         hx_p0 <= '0;
         vy_p0 <= (vy_p0 == V_LAST) ? '0 : vy_p0 + 1'b1;
      end else begin
         hx_p0 <= hx_p0 + 1'b1;
      end
   end

   // Region decode of the current counter position
   always_comb begin
      de_p0     = vld_p0 && (hx_p0 < H_ACT) && (vy_p0 < V_ACT);
      hs_act_p0 = vld_p0 && (hx_p0 >= HS_BEG) && (hx_p0 < HS_END);
      vs_act_p0 = vld_p0 && (vy_p0 >= VS_BEG) && (vy_p0 < VS_END);
      ls_p0     = vld_p0 && (hx_p0 == '0);
      fs_p0     = ls_p0 && (vy_p0 == '0);
   end

   // ---- stage p1: registered, mutually aligned outputs ----
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         x           <= '0;
         y           <= '0;
         de          <= 1'b0;
         hsync       <= !HS_POL;
         vsync       <= !VS_POL;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         running     <= 1'b0;
      end else begin
         x           <= vld_p0 ? hx_p0 : '0;
         y           <= vld_p0 ? vy_p0 : '0;
         de          <= de_p0;
         hsync       <= hs_act_p0 ? HS_POL : !HS_POL;
         vsync       <= vs_act_p0 ? VS_POL : !VS_POL;
         line_start  <= ls_p0;
         frame_start <= fs_p0;
         running     <= vld_p0;
      end
   end

   assign pix_ready = de;

   // Sticky underrun: a new underrun takes priority over a coincident clear
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         underrun <= 1'b0;
      end else if (de && !pix_valid) begin
         underrun <= 1'b1;
      end else if (underrun_clr) begin
         underrun <= 1'b0;
      end
   end

endmodule
